// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the byte-stream RAM loader.
package ram_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 2 * BYTE_W;
    localparam int unsigned CNT_W      = WORD_W + 1;
    localparam int unsigned AWIDTH_DEF = 8;
    localparam int unsigned MAX_WORDS  = 1 << AWIDTH_DEF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_WRITE,
        S_CHK_LO,
        S_CHK_HI,
        S_DONE,
        S_ERR
    } state_t;

    // States in which the loader takes a byte from the stream
    function automatic logic accepts_byte(input state_t s);
        return (s == S_HDR_LO) || (s == S_HDR_HI) || (s == S_DAT_LO) ||
               (s == S_DAT_HI) || (s == S_CHK_LO) || (s == S_CHK_HI);
    endfunction

    function automatic logic is_rest_state(input state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
    endfunction

endpackage

// File: rtl/ram_loader_byte2word.sv
// Pairs a low and a high byte into a word and emits a one-cycle word strobe.
module ram_loader_byte2word
    import ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              lo_we,
    input  logic              hi_we,
    output logic [WORD_W-1:0] word_c,
    output logic [WORD_W-1:0] word,
    output logic              word_vld
);

    logic [BYTE_W-1:0] lo_q;

    // Word as it would complete with the byte currently on the stream
    assign word_c = {byte_in, lo_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_q     <= '0;
            word     <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= hi_we;
            if (lo_we) begin
                lo_q <= byte_in;
            end
            if (hi_we) begin
                word <= word_c;
            end
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Loads a length-prefixed little-endian byte stream into a RAM while holding the core in reset.
// Optional checksum trailer is built when RAM_LOADER_CHKSUM_EN is defined.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    parameter int unsigned DWIDTH = WORD_W
) (
    input  logic              PCLK,
    input  logic              NSYSRESET,
    input  logic              LD_START,
    input  logic [BYTE_W-1:0] BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              WEN,
    output logic [AWIDTH-1:0] WADDR,
    output logic [DWIDTH-1:0] WD,
    output logic              HOLD,
    output logic              LD_DONE,
    output logic              LD_ERR,
    output logic [WORD_W-1:0] CHKSUM
);

    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'((AWIDTH == AWIDTH_DEF) ? MAX_WORDS : (1 << AWIDTH));

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] waddr_q;
    logic [WORD_W-1:0] n_q;
    logic [WORD_W-1:0] chksum_q;
    logic [WORD_W-1:0] word_c;
    logic [WORD_W-1:0] word;
    logic              word_vld;
    logic              ready_q, hold_q, done_q, err_q;
    logic              fire_c, lo_we_c, hi_we_c, start_c, n_ok_c, last_c;

    assign fire_c = BYTE_VALID & ready_q;
    assign n_ok_c = (word_c != '0) && ({1'b0, word_c} <= LIMIT);
    assign last_c = (WORD_W'(addr_q) == (n_q - WORD_W'(1)));

    ram_loader_byte2word u_byte2word (
        .clk      (PCLK),
        .rst_n    (NSYSRESET),
        .byte_in  (BYTE_IN),
        .lo_we    (lo_we_c),
        .hi_we    (hi_we_c),
        .word_c   (word_c),
        .word     (word),
        .word_vld (word_vld)
    );

    // Next-state and handshake decode
    always_comb begin
        state_d = state_q;
        lo_we_c = 1'b0;
        hi_we_c = 1'b0;
        start_c = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (LD_START) begin
                    start_c = 1'b1;
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (fire_c) begin
                    lo_we_c = 1'b1;
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (fire_c) begin
                    state_d = n_ok_c ? S_DAT_LO : S_ERR;
                end
            end
            S_DAT_LO: begin
                if (fire_c) begin
                    lo_we_c = 1'b1;
                    state_d = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (fire_c) begin
                    hi_we_c = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
`ifdef RAM_LOADER_CHKSUM_EN
                state_d = last_c ? S_CHK_LO : S_DAT_LO;
`else
                state_d = last_c ? S_DONE : S_DAT_LO;
`endif
            end
`ifdef RAM_LOADER_CHKSUM_EN
            S_CHK_LO: begin
                if (fire_c) begin
                    lo_we_c = 1'b1;
                    state_d = S_CHK_HI;
                end
            end
            S_CHK_HI: begin
                if (fire_c) begin
                    state_d = (word_c == chksum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and status outputs are registered from the next state so they align with it
    always_ff @(posedge PCLK) begin
        if (!NSYSRESET) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= accepts_byte(state_d);
            hold_q  <= !is_rest_state(state_d);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    // Address counter, word count, running checksum and write address
    always_ff @(posedge PCLK) begin
        if (!NSYSRESET) begin
            addr_q   <= '0;
            waddr_q  <= '0;
            n_q      <= '0;
            chksum_q <= '0;
        end else begin
            if (start_c) begin
                addr_q   <= '0;
                chksum_q <= '0;
            end else if (state_q == S_WRITE) begin
                addr_q   <= addr_q + AWIDTH'(1);
                chksum_q <= chksum_q + word;
            end
            if ((state_q == S_HDR_HI) && fire_c) begin
                n_q <= word_c;
            end
            if (hi_we_c) begin
                waddr_q <= addr_q;
            end
        end
    end

    assign BYTE_READY = ready_q;
    assign HOLD       = hold_q;
    assign LD_DONE    = done_q;
    assign LD_ERR     = err_q;
    assign CHKSUM     = chksum_q;
    assign WEN        = word_vld;
    assign WADDR      = waddr_q;
    assign WD         = DWIDTH'(word);

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter AWIDTH, default 8, RAM address width (256 words).
REQ-002 Parameter DWIDTH, default 16, RAM word width; fixed at 16 by the byte protocol.
REQ-003 PCLK  input  1  single clock; all state changes on rising edge.
REQ-004 NSYSRESET  input  1  reset, synchronous, active-low.
REQ-005 LD_START  input  1  single-cycle pulse; begins a load session.
REQ-006 BYTE_IN  input  8  stream data byte.
REQ-007 BYTE_VALID  input  1  BYTE_IN valid.
REQ-008 BYTE_READY  output  1  loader accepts byte; transfer when BYTE_VALID and BYTE_READY both high.
REQ-009 WEN  output  1  active-high RAM write strobe; the RAM wrapper inverts it.
REQ-010 WADDR  output  AWIDTH  RAM write address.
REQ-011 WD  output  DWIDTH  RAM write data.
REQ-012 HOLD  output  1  high while loading; holds the sequencer core in reset.
REQ-013 LD_DONE  output  1  sticky; load completed successfully.
REQ-014 LD_ERR  output  1  sticky; load failed.
REQ-015 CHKSUM  output  16  running sum of written words, mod 2^16.

Function
REQ-016 States: IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, WRITE, CHK_LO, CHK_HI, DONE, ERR.
REQ-017 Protocol: 16-bit word count N (low byte first), then N data words (low byte first), then a 16-bit checksum (low byte first); the checksum is present only when the macro is enabled.
REQ-018 BYTE_READY is high only in HDR_LO, HDR_HI, DAT_LO, DAT_HI, CHK_LO and CHK_HI.
REQ-019 In IDLE, DONE or ERR, LD_START moves to HDR_LO next cycle and clears LD_DONE, LD_ERR, CHKSUM and the address counter; a byte valid in the same cycle is not accepted.
REQ-020 LD_START is ignored in all other states.
REQ-021 In HDR_HI, if the completed N is 0 or greater than 2^AWIDTH, the next state is ERR; otherwise it is DAT_LO.
REQ-022 Accepting the DAT_HI byte moves to WRITE; in the WRITE cycle WEN=1 for exactly one cycle, with WD={hi,lo} and WADDR=current address.
REQ-023 The address counter increments after WRITE and CHKSUM adds WD in the same edge; CHKSUM wraps modulo 2^16.
REQ-024 After WRITE: if the word written was word N, the next state is CHK_LO (macro on) or DONE (macro off); otherwise the next state is DAT_LO.
REQ-025 For N=256, WADDR reaches 255 on the last write; the counter wrap to 0 is never used for a write.
REQ-026 Latency: WEN is high in the cycle immediately after the high byte is accepted.
REQ-027 HOLD is high in every state except IDLE, DONE and ERR.
REQ-028 In DONE: LD_DONE=1. In ERR: LD_ERR=1. Both flags stay set until the next LD_START or reset.
REQ-029 WEN is 0 in every state except WRITE; WADDR and WD hold their values outside WRITE.

Reset
REQ-030 When NSYSRESET=0 at a clock edge, the state becomes IDLE.
REQ-031 On reset: WEN=0, BYTE_READY=0, HOLD=0, LD_DONE=0, LD_ERR=0, WADDR=0, WD=0, CHKSUM=0.
REQ-032 Reset during a load abandons the load at once; no further writes occur, and words already written stay in the RAM.

Configuration
REQ-033 Macro RAM_LOADER_CHKSUM_EN.
REQ-034 With the macro defined: CHK_LO and CHK_HI accept the trailer; a match with CHKSUM goes to DONE, a mismatch goes to ERR.
REQ-035 Without the macro: the CHK states are not built, WRITE of word N goes directly to DONE, and CHKSUM is still output.

Structure
REQ-036 The shared package holds the state enum type, the byte-assembly widths and the limit constant MAX_WORDS = 2^AWIDTH.
REQ-037 The module has one sub-module, ram_loader_byte2word: it pairs low and high bytes and produces a one-cycle word-valid strobe.

Verification
REQ-038 N=2, words 0x1234 and 0xABCD, trailer 0xBE01 -> writes (0,0x1234) then (1,0xABCD); LD_DONE=1, CHKSUM=0xBE01.
REQ-039 Header N=0 -> ERR; LD_ERR=1, no WEN pulse. Header N=257 -> the same.
REQ-040 N=1, word 0x0001, trailer 0x0002 (macro on) -> one write, then LD_ERR=1; without the macro the trailer is not consumed and LD_DONE=1.
REQ-041 N=256, data k -> WADDR 0..255, LD_DONE=1; BYTE_VALID toggling every other cycle gives identical writes.
REQ-042 NSYSRESET low after 3 words of N=10 -> IDLE next cycle, HOLD=0, no further WEN; a following LD_START and a full load succeed.
REQ-043 LD_START pulsed in DAT_LO -> ignored; the load completes normally.
